// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory port signals around mem_port_arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ready;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_xfer_size;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_xfer_size;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_xfer_size, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready,
      output mem_addr, mem_re, mem_we, mem_wdata, mem_xfer_size, stall
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_xfer_size, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready,
      input  mem_addr, mem_re, mem_we, mem_wdata, mem_xfer_size, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data over fetch) sequencer for a single-ported memory with MEM_LAT-cycle accesses.
// Service is MEM_LAT+2 cycles per request; requesters are held off via stall until their ready pulse.
module mem_port_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int MEM_LAT = 2
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);
   localparam int                CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(MEM_LAT - 1);
   localparam logic              LAT1  = (MEM_LAT == 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [3:0]        size_q, size_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic              if_ready_q, if_ready_d;
   logic              d_ready_q, d_ready_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      size_d     = size_q;
      mem_re_d   = 1'b0;
      mem_we_d   = 1'b0;
      if_ready_d = 1'b0;
      d_ready_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;

      case (state_q)
         IDLE: begin
            // Data wins a tie: it belongs to the older instruction in the pipe.
            if (bus.d_req) begin
               state_d  = ACCESS;
               owner_d  = 1'b1;
               cnt_d    = '0;
               addr_d   = bus.d_addr;
               wdata_d  = bus.d_wdata;
               we_d     = bus.d_we;
               size_d   = bus.d_xfer_size;
               mem_re_d = ~bus.d_we;
               mem_we_d = bus.d_we & LAT1;
            end else if (bus.if_req) begin
               state_d  = ACCESS;
               owner_d  = 1'b0;
               cnt_d    = '0;
               addr_d   = bus.if_addr;
               wdata_d  = '0;
               we_d     = 1'b0;
               size_d   = 4'd4;
               mem_re_d = 1'b1;
            end
         end
         ACCESS: begin
            if (cnt_q == LAST) begin
               state_d = DONE;
               if (owner_q) begin
                  d_rdata_d = bus.mem_rdata;
                  d_ready_d = 1'b1;
               end else begin
                  if_rdata_d = bus.mem_rdata[31:0];
                  if_ready_d = 1'b1;
               end
            end else begin
               cnt_d    = cnt_q + 1'b1;
               mem_re_d = ~we_q;
               mem_we_d = we_q & (cnt_d == LAST);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         size_q     <= '0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         size_q     <= size_d;
         mem_re_q   <= mem_re_d;
         mem_we_q   <= mem_we_d;
         if_ready_q <= if_ready_d;
         d_ready_q  <= d_ready_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_xfer_size = size_q;
   assign bus.mem_re        = mem_re_q;
   // Reset landing on the final store cycle must not commit the write.
   assign bus.mem_we        = mem_we_q & ~reset;
   assign bus.if_ready      = if_ready_q;
   assign bus.d_ready       = d_ready_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.d_rdata       = d_rdata_q;
   assign bus.stall         = (bus.if_req & ~if_ready_q) | (bus.d_req & ~d_ready_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table on a MEM_LAT=2 instance plus a store/load sequence on MEM_LAT=3.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst2, rst3, clr;
   int   total = 0;
   int   bad   = 0;

   mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b2 ();
   mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b3 ();

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dut2 (.clk(clk), .reset(rst2), .bus(b2));
   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) dut3 (.clk(clk), .reset(rst3), .bus(b3));

   function automatic logic [63:0] init_val(input logic [7:0] a);
      case (a)
         8'h00:   return 64'h11111111_00000013;
         8'h04:   return 64'h22222222_00100093;
         8'h10:   return 64'h00000000_91000421;
         8'h18:   return 64'h01234567_89ABCDEF;
         8'h20:   return 64'h33333333_00208113;
         8'h30:   return 64'hA5A5A5A5_5A5A5A5A;
         8'h40:   return 64'h11223344_55667788;
         default: return {56'h0, a};
      endcase
   endfunction

   // Toy memories keyed by the low address byte; unwritten locations read their initial pattern.
   logic [63:0]  m2 [256];
   logic [63:0]  m3 [256];
   logic [255:0] v2, v3;

   always @(posedge clk) begin
      if (clr) begin
         v2 <= '0;
         v3 <= '0;
      end else begin
         if (b2.mem_we) begin
            m2[b2.mem_addr[7:0]] <= b2.mem_wdata;
            v2[b2.mem_addr[7:0]] <= 1'b1;
         end
         if (b3.mem_we) begin
            m3[b3.mem_addr[7:0]] <= b3.mem_wdata;
            v3[b3.mem_addr[7:0]] <= 1'b1;
         end
      end
   end

   assign b2.mem_rdata = v2[b2.mem_addr[7:0]] ? m2[b2.mem_addr[7:0]] : init_val(b2.mem_addr[7:0]);
   assign b3.mem_rdata = v3[b3.mem_addr[7:0]] ? m3[b3.mem_addr[7:0]] : init_val(b3.mem_addr[7:0]);

   typedef struct {
      logic        rst;
      logic        ifq;
      logic [63:0] ia;
      logic        dq;
      logic        dwe;
      logic [63:0] da;
      logic [63:0] dw;
      logic        e_stall;
      logic        e_re;
      logic        e_we;
      logic        e_ifr;
      logic        e_dr;
      logic        ca;
      logic [63:0] e_addr;
      logic [3:0]  e_sz;
      logic [63:0] e_dat;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(input logic rst, input logic ifq, input logic [63:0] ia,
                              input logic dq, input logic dwe, input logic [63:0] da, input logic [63:0] dw,
                              input logic e_stall, input logic e_re, input logic e_we,
                              input logic e_ifr, input logic e_dr,
                              input logic ca, input logic [63:0] e_addr, input logic [3:0] e_sz,
                              input logic [63:0] e_dat);
      vec_t r;
      r.rst = rst; r.ifq = ifq; r.ia = ia; r.dq = dq; r.dwe = dwe; r.da = da; r.dw = dw;
      r.e_stall = e_stall; r.e_re = e_re; r.e_we = e_we; r.e_ifr = e_ifr; r.e_dr = e_dr;
      r.ca = ca; r.e_addr = e_addr; r.e_sz = e_sz; r.e_dat = e_dat;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      clr  = 1'b1;
      rst2 = 1'b1;
      rst3 = 1'b1;
      b2.if_req = 1'b0; b2.if_addr = '0; b2.d_req = 1'b0; b2.d_we = 1'b0;
      b2.d_addr = '0;   b2.d_wdata = '0; b2.d_xfer_size = 4'd8;
      b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
      b3.d_addr = '0;   b3.d_wdata = '0; b3.d_xfer_size = 4'd8;
      repeat (2) @(posedge clk);
      #1;
      rst2 = 1'b0;
      rst3 = 1'b0;
      clr  = 1'b0;
      @(negedge clk);
      chk("rst.if_ready", b2.if_ready, 0);
      chk("rst.d_ready",  b2.d_ready,  0);
      chk("rst.mem_re",   b2.mem_re,   0);
      chk("rst.mem_we",   b2.mem_we,   0);
      chk("rst.if_rdata", b2.if_rdata, 0);
      chk("rst.d_rdata",  b2.d_rdata,  0);
      chk("rst.mem_addr", b2.mem_addr, 0);
      chk("rst.stall",    b2.stall,    0);
      chk("rst3.mem_re",  b3.mem_re,   0);
      chk("rst3.d_rdata", b3.d_rdata,  0);

      //           rst ifq ia     dq dwe da     dw       stl re we ifr dr  ca addr  sz  data
      // fetch 0x10
      vt.push_back(v(0, 1, 'h10,  0, 0, 0,     0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 1, 'h10,  0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h10, 4, 0));
      vt.push_back(v(0, 1, 'h10,  0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h10, 4, 0));
      vt.push_back(v(0, 1, 'h10,  0, 0, 0,     0,       0, 0, 0, 1, 0,  0, 0,    0, 'h91000421));
      vt.push_back(v(0, 0, 0,     0, 0, 0,     0,       0, 0, 0, 0, 0,  0, 0,    0, 0));
      // simultaneous fetch 0x20 and load 0x40
      vt.push_back(v(0, 1, 'h20,  1, 0, 'h40,  0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 1, 'h20,  1, 0, 'h40,  0,       1, 1, 0, 0, 0,  1, 'h40, 8, 0));
      vt.push_back(v(0, 1, 'h20,  1, 0, 'h40,  0,       1, 1, 0, 0, 0,  1, 'h40, 8, 0));
      vt.push_back(v(0, 1, 'h20,  1, 0, 'h40,  0,       1, 0, 0, 0, 1,  0, 0,    0, 'h1122334455667788));
      vt.push_back(v(0, 1, 'h20,  0, 0, 0,     0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 1, 'h20,  0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h20, 4, 0));
      vt.push_back(v(0, 1, 'h20,  0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h20, 4, 0));
      vt.push_back(v(0, 1, 'h20,  0, 0, 0,     0,       0, 0, 0, 1, 0,  0, 0,    0, 'h00208113));
      vt.push_back(v(0, 0, 0,     0, 0, 0,     0,       0, 0, 0, 0, 0,  0, 0,    0, 0));
      // back-to-back fetches 0x0 then 0x4
      vt.push_back(v(0, 1, 'h0,   0, 0, 0,     0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 1, 'h0,   0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h0,  4, 0));
      vt.push_back(v(0, 1, 'h0,   0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h0,  4, 0));
      vt.push_back(v(0, 1, 'h0,   0, 0, 0,     0,       0, 0, 0, 1, 0,  0, 0,    0, 'h00000013));
      vt.push_back(v(0, 1, 'h4,   0, 0, 0,     0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 1, 'h4,   0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h4,  4, 0));
      vt.push_back(v(0, 1, 'h4,   0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h4,  4, 0));
      vt.push_back(v(0, 1, 'h4,   0, 0, 0,     0,       0, 0, 0, 1, 0,  0, 0,    0, 'h00100093));
      vt.push_back(v(0, 0, 0,     0, 0, 0,     0,       0, 0, 0, 0, 0,  0, 0,    0, 0));
      // load 0x18 rising in the last cycle of a fetch access
      vt.push_back(v(0, 1, 'h10,  0, 0, 0,     0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 1, 'h10,  0, 0, 0,     0,       1, 1, 0, 0, 0,  1, 'h10, 4, 0));
      vt.push_back(v(0, 1, 'h10,  1, 0, 'h18,  0,       1, 1, 0, 0, 0,  1, 'h10, 4, 0));
      vt.push_back(v(0, 1, 'h10,  1, 0, 'h18,  0,       1, 0, 0, 1, 0,  0, 0,    0, 'h91000421));
      vt.push_back(v(0, 0, 0,     1, 0, 'h18,  0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 0, 0,     1, 0, 'h18,  0,       1, 1, 0, 0, 0,  1, 'h18, 8, 0));
      vt.push_back(v(0, 0, 0,     1, 0, 'h18,  0,       1, 1, 0, 0, 0,  1, 'h18, 8, 0));
      vt.push_back(v(0, 0, 0,     1, 0, 'h18,  0,       0, 0, 0, 0, 1,  0, 0,    0, 'h0123456789ABCDEF));
      vt.push_back(v(0, 0, 0,     0, 0, 0,     0,       0, 0, 0, 0, 0,  0, 0,    0, 0));
      // store to 0x30 aborted by reset in its final cycle, then load back the old value
      vt.push_back(v(0, 0, 0,     1, 1, 'h30,  'h5555,  1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 0, 0,     1, 1, 'h30,  'h5555,  1, 0, 0, 0, 0,  1, 'h30, 8, 0));
      vt.push_back(v(1, 0, 0,     1, 1, 'h30,  'h5555,  1, 0, 0, 0, 0,  1, 'h30, 8, 0));
      vt.push_back(v(0, 0, 0,     1, 0, 'h30,  0,       1, 0, 0, 0, 0,  0, 0,    0, 0));
      vt.push_back(v(0, 0, 0,     1, 0, 'h30,  0,       1, 1, 0, 0, 0,  1, 'h30, 8, 0));
      vt.push_back(v(0, 0, 0,     1, 0, 'h30,  0,       1, 1, 0, 0, 0,  1, 'h30, 8, 0));
      vt.push_back(v(0, 0, 0,     1, 0, 'h30,  0,       0, 0, 0, 0, 1,  0, 0,    0, 'hA5A5A5A55A5A5A5A));
      vt.push_back(v(0, 0, 0,     0, 0, 0,     0,       0, 0, 0, 0, 0,  0, 0,    0, 0));

      foreach (vt[i]) begin
         @(posedge clk);
         #1;
         rst2         = vt[i].rst;
         b2.if_req    = vt[i].ifq;
         b2.if_addr   = vt[i].ia;
         b2.d_req     = vt[i].dq;
         b2.d_we      = vt[i].dwe;
         b2.d_addr    = vt[i].da;
         b2.d_wdata   = vt[i].dw;
         @(negedge clk);
         chk($sformatf("v%0d.stall", i),    b2.stall,    vt[i].e_stall);
         chk($sformatf("v%0d.mem_re", i),   b2.mem_re,   vt[i].e_re);
         chk($sformatf("v%0d.mem_we", i),   b2.mem_we,   vt[i].e_we);
         chk($sformatf("v%0d.if_ready", i), b2.if_ready, vt[i].e_ifr);
         chk($sformatf("v%0d.d_ready", i),  b2.d_ready,  vt[i].e_dr);
         if (vt[i].ca) begin
            chk($sformatf("v%0d.mem_addr", i), b2.mem_addr,      vt[i].e_addr);
            chk($sformatf("v%0d.mem_size", i), b2.mem_xfer_size, vt[i].e_sz);
         end
         if (vt[i].e_ifr) chk($sformatf("v%0d.if_rdata", i), {32'h0, b2.if_rdata}, vt[i].e_dat);
         if (vt[i].e_dr)  chk($sformatf("v%0d.d_rdata", i),  b2.d_rdata,          vt[i].e_dat);
      end

      // MEM_LAT=3 store of 0xDEADBEEF to 0x8
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            b3.d_req = 1'b1; b3.d_we = 1'b1; b3.d_addr = 64'h8;
            b3.d_wdata = 64'hDEADBEEF; b3.d_xfer_size = 4'd8;
         end
         if (c == 5) b3.d_req = 1'b0;
         @(negedge clk);
         chk($sformatf("st%0d.mem_we", c),  b3.mem_we,  (c == 3) ? 64'd1 : 64'd0);
         chk($sformatf("st%0d.mem_re", c),  b3.mem_re,  0);
         chk($sformatf("st%0d.d_ready", c), b3.d_ready, (c == 4) ? 64'd1 : 64'd0);
         chk($sformatf("st%0d.stall", c),   b3.stall,   (c <= 3) ? 64'd1 : 64'd0);
         if (c == 3) begin
            chk("st3.mem_addr",  b3.mem_addr,      64'h8);
            chk("st3.mem_wdata", b3.mem_wdata,     64'hDEADBEEF);
            chk("st3.mem_size",  b3.mem_xfer_size, 64'd8);
         end
      end

      // MEM_LAT=3 load back from 0x8
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 64'h8; b3.d_wdata = '0;
         end
         if (c == 5) b3.d_req = 1'b0;
         @(negedge clk);
         chk($sformatf("ld%0d.mem_re", c),  b3.mem_re,  (c >= 1 && c <= 3) ? 64'd1 : 64'd0);
         chk($sformatf("ld%0d.mem_we", c),  b3.mem_we,  0);
         chk($sformatf("ld%0d.d_ready", c), b3.d_ready, (c == 4) ? 64'd1 : 64'd0);
         if (c == 4) chk("ld4.d_rdata", b3.d_rdata, 64'hDEADBEEF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Fixed-priority arbiter and sequencer for one unified, single-ported, multi-cycle memory.
- Shared between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage).
- Grants one access at a time and holds the memory port stable for the memory's fixed latency.
- Captures read data and returns a one-cycle `ready`, and drives a stall to freeze the pipeline while any request is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- `MEM_LAT`, default 2: memory access cycles, ≥1.

Ports:
- `clk`  in  1: clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high.
- `if_req`  in  1: fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W: fetch address; stable while `if_req`.
- `if_rdata`  out  32: fetched instruction, valid while `if_ready`.
- `if_ready`  out  1: one-cycle fetch completion pulse.
- `d_req`  in  1: data request; held until `d_ready`.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: store data.
- `d_xfer_size`  in  4: bytes to transfer.
- `d_rdata`  out  DATA_W: load data, valid while `d_ready`.
- `d_ready`  out  1: one-cycle data completion pulse.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_re`  out  1: memory read enable.
- `mem_we`  out  1: memory write enable.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_xfer_size`  out  4: memory transfer size.
- `mem_rdata`  in  DATA_W: memory read data, valid in the final access cycle.
- `stall`  out  1: freeze the pipeline.

## Operation
States are IDLE, ACCESS and DONE. A latency counter `cnt` (width clog2(MEM_LAT), minimum 1) and a registered owner bit (0 = fetch, 1 = data) record the active access.

IDLE:
- `d_req` → ACCESS, owner = data, `cnt` = 0.
- Else `if_req` → ACCESS, owner = fetch, `cnt` = 0.
- Else stay in IDLE.
- Data always wins when both requests are high, because it belongs to the older instruction.
- The grant is registered. Address, write data, `d_we` and size are latched into internal registers at the grant edge and ignored afterwards.

ACCESS:
- `mem_addr`, `mem_wdata` and `mem_xfer_size` are driven from the latched registers every cycle.
  - Fetch: `mem_xfer_size` = 4'd4 and `mem_wdata` = 0.
- `mem_re` = 1 in every ACCESS cycle of a fetch or a load.
- `mem_we` = 1 only in the final ACCESS cycle (`cnt` == MEM_LAT-1) of a store, gated with `~reset`. Each store therefore commits exactly once.
- `cnt` increments each cycle. When `cnt` == MEM_LAT-1:
  - Move to DONE.
  - Capture `mem_rdata` into the owner's read-data register (fetch keeps bits [31:0]).

DONE:
- The owner's `ready` = 1 for this cycle only.
- New requests are ignored; the next state is always IDLE.
- Requesters drop or change `req` in the cycle after they see `ready`.

Stall:
- `stall` = (`if_req` & ~`if_ready`) | (`d_req` & ~`d_ready`). Combinational from inputs and registered state.

Memory port outside ACCESS:
- `mem_re` = `mem_we` = 0.
- `mem_addr`, `mem_wdata` and `mem_xfer_size` hold their last value. They are don't-care.

`if_rdata` and `d_rdata` are registered and hold their value until the next capture for the same owner.

## Timing
- Request high in IDLE at cycle 0 → ACCESS in cycles 1..MEM_LAT → `ready` in cycle MEM_LAT+1 → IDLE in cycle MEM_LAT+2.
- Service time is MEM_LAT+2 cycles per transaction, including the mandatory IDLE cycle between transactions. Back-to-back same-requester throughput is one access per MEM_LAT+2 cycles.
- A losing fetch request is granted in the IDLE cycle after the data transaction's DONE cycle, provided `if_req` is still high.
- A request rising during ACCESS or DONE waits for the next IDLE.
- Reset values: state IDLE, `cnt` 0, owner 0, `if_ready` = `d_ready` = 0, `mem_re` = `mem_we` = 0, `if_rdata` = 0, `d_rdata` = 0, latched registers 0.
- Reset mid-ACCESS aborts the access: no write is committed, even in the final cycle, because `mem_we` is gated by `reset`. No `ready` is produced, and the next cycle is IDLE.
- Reset during DONE drops `ready` at that edge.
- MEM_LAT = 1: ACCESS lasts one cycle, and `mem_we`/`mem_re` are asserted in that cycle.

## Test plan
1. **Fetch read, MEM_LAT = 2.** Stimulus: `if_req` = 1, `if_addr` = 0x10, memory returns 0x00000000_91000421.
   - `mem_re` = 1 in cycles 1–2 with `mem_addr` = 0x10 and `mem_xfer_size` = 4.
   - `if_ready` = 1 in cycle 3 with `if_rdata` = 0x91000421.
   - `stall` = 1 in cycles 0–2 and 0 in cycle 3.
2. **Simultaneous requests.** Stimulus: `if_req` and `d_req` (load, `d_addr` = 0x40) both rise in cycle 0.
   - Data is served first: `d_ready` = 1 in cycle 3.
   - Fetch is granted in cycle 4: `if_ready` = 1 in cycle 7.
   - `stall` stays high through cycle 6.
3. **Store.** Stimulus: `d_we` = 1, `d_addr` = 0x8, `d_wdata` = 0xDEADBEEF, `d_xfer_size` = 8, MEM_LAT = 3.
   - `mem_we` = 1 only in cycle 3, with `mem_re` = 0.
   - `d_ready` = 1 in cycle 4.
   - A subsequent load from 0x8 returns 0xDEADBEEF.
4. **Reset in final ACCESS cycle of a store.** Stimulus: `reset` asserted in cycle 2 with MEM_LAT = 2.
   - `mem_we` = 0 in cycle 2.
   - No `d_ready` pulse; state is IDLE in cycle 3.
   - Memory at the target address is unchanged.
5. **Back-to-back fetches.** Stimulus: fetch of 0x0, then `if_addr` changed to 0x4 with `if_req` held high.
   - `if_ready` pulses in cycles 3 and 7.
   - `mem_addr` = 0x4 in cycles 5–6.
   - No extra or missed grants.
6. **Late data request.** Stimulus: `d_req` rises in cycle 2 of a fetch ACCESS (MEM_LAT = 2).
   - The fetch completes unaffected, with `if_ready` in cycle 3.
   - The data request is granted at cycle 4, with `d_ready` in cycle 7.
